// File: rtl/kp_int_receiver_if.sv
// Bus bundle between the keypad/CPU side and kp_int_receiver.
// master = keypad FSM + CPU (drives strobes/data), slave = receiver.
interface kp_int_receiver_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic              int_in;
  logic [DATA_W-1:0] key_data;
  logic              int_en;
  logic              int_ack;
  logic              rd_strobe;
  logic              irq_out;
  logic [DATA_W-1:0] key_out;
  logic [CNT_W-1:0]  count;
  logic              overflow;

  modport master (
    output int_in, key_data, int_en, int_ack, rd_strobe,
    input  irq_out, key_out, count, overflow
  );

  modport slave (
    input  int_in, key_data, int_en, int_ack, rd_strobe,
    output irq_out, key_out, count, overflow
  );
endinterface

// File: rtl/kp_int_receiver.sv
// Keypad interrupt receiver: pulse qualifier, key-code FIFO and IRQ request FSM.
// Optional macro KP_INT_OVERWRITE_EN: a push into a full FIFO replaces the oldest entry.
module kp_int_receiver #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned MIN_PULSE = 2
) (
  input  logic clk,
  input  logic rst,
  kp_int_receiver_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned HI_W  = 3;

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t            state, state_next;
  logic [HI_W-1:0]   hi_cnt, hi_cnt_next;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr, wr_next, rd_next;
  logic [CNT_W-1:0]  count_q, count_next;
  logic [DATA_W-1:0] key_q, head_next;
  logic              overflow_q, irq_q;
  logic              capture, full, pop, push_do, drop_oldest, ov_set, inc;

  // Pulse qualifier: one capture per pulse, on the sample where hi_cnt reaches MIN_PULSE
  always_comb begin
    capture     = bus.int_in && (hi_cnt == HI_W'(MIN_PULSE - 1));
    hi_cnt_next = hi_cnt;
    if (!bus.int_in)
      hi_cnt_next = '0;
    else if (hi_cnt != HI_W'(MIN_PULSE))
      hi_cnt_next = hi_cnt + HI_W'(1);
  end

  // FIFO pointer/count bookkeeping and registered show-ahead head
  always_comb begin
    pop  = bus.rd_strobe && (count_q != '0);
    full = (count_q == CNT_W'(DEPTH));
`ifdef KP_INT_OVERWRITE_EN
    push_do     = capture;
    drop_oldest = capture && full && !pop;
`else
    push_do     = capture && (!full || pop);
    drop_oldest = 1'b0;
`endif
    ov_set  = capture && full && !pop;
    inc     = push_do && !drop_oldest;
    wr_next = push_do ? wr_ptr + PTR_W'(1) : wr_ptr;
    rd_next = (pop || drop_oldest) ? rd_ptr + PTR_W'(1) : rd_ptr;

    count_next = count_q;
    if (inc && !pop)
      count_next = count_q + CNT_W'(1);
    else if (!inc && pop)
      count_next = count_q - CNT_W'(1);

    // A fresh push becomes the head when it lands where the new read pointer points
    if (count_next == '0)
      head_next = '0;
    else if (push_do && (rd_next == wr_ptr))
      head_next = bus.key_data;
    else
      head_next = mem[rd_next];
  end

  // Request FSM next-state
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (count_q != '0 && bus.int_en) state_next = REQ;
      REQ: begin
        if (bus.int_ack)      state_next = SERVICE;
        else if (!bus.int_en) state_next = IDLE;
      end
      SERVICE: if (pop) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      irq_q      <= 1'b0;
      hi_cnt     <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      key_q      <= '0;
    end else begin
      state      <= state_next;
      irq_q      <= (state_next == REQ);
      hi_cnt     <= hi_cnt_next;
      wr_ptr     <= wr_next;
      rd_ptr     <= rd_next;
      count_q    <= count_next;
      overflow_q <= overflow_q | ov_set;
      key_q      <= head_next;
    end
  end

  // Storage needs no reset: entries are only visible through the counted head
  always_ff @(posedge clk) begin
    if (push_do)
      mem[wr_ptr] <= bus.key_data;
  end

  assign bus.irq_out  = irq_q;
  assign bus.key_out  = key_q;
  assign bus.count    = count_q;
  assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_kp_int_receiver.sv
// Scoreboard bench for kp_int_receiver: expected key codes are queued as pulses are
// driven and compared against key_out as the ISR sequence reads them back.
module tb_kp_int_receiver;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned DEPTH     = 4;
  localparam int unsigned MIN_PULSE = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  kp_int_receiver_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  kp_int_receiver #(.DATA_W(DATA_W), .DEPTH(DEPTH), .MIN_PULSE(MIN_PULSE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [DATA_W-1:0] sb [$];
  logic ov_exp = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic model_push(input logic [DATA_W-1:0] code);
    if (sb.size() < DEPTH) begin
      sb.push_back(code);
    end else begin
      ov_exp = 1'b1;
`ifdef KP_INT_OVERWRITE_EN
      void'(sb.pop_front());
      sb.push_back(code);
`endif
    end
  endtask

  task automatic send_key(input logic [DATA_W-1:0] code, input int len);
    bus.key_data = code;
    bus.int_in   = 1'b1;
    tick(len);
    bus.int_in   = 1'b0;
    tick(1);
    if (len >= int'(MIN_PULSE)) model_push(code);
  endtask

  task automatic wait_irq(input string tag);
    int n = 0;
    while (!bus.irq_out && n < 20) begin
      tick(1);
      n++;
    end
    check(tag, 32'(bus.irq_out), 32'd1);
  endtask

  // ISR sequence: wait for request, vector (ack), read the key port
  task automatic read_key(input string tag);
    logic [DATA_W-1:0] exp;
    wait_irq({tag, "_irq"});
    bus.int_ack = 1'b1;
    tick(1);
    bus.int_ack = 1'b0;
    check({tag, "_irq_ack"}, 32'(bus.irq_out), 32'd0);
    check({tag, "_sb"}, 32'(sb.size() > 0), 32'd1);
    exp = (sb.size() > 0) ? sb.pop_front() : '0;
    check({tag, "_key"}, 32'(bus.key_out), 32'(exp));
    bus.rd_strobe = 1'b1;
    tick(1);
    bus.rd_strobe = 1'b0;
    check({tag, "_gap"}, 32'(bus.irq_out), 32'd0);
    check({tag, "_cnt"}, 32'(bus.count), 32'(sb.size()));
    if (sb.size() == 0) check({tag, "_key_empty"}, 32'(bus.key_out), 32'd0);
  endtask

  initial begin
    rst           = 1'b1;
    bus.int_in    = 1'b0;
    bus.key_data  = '0;
    bus.int_en    = 1'b0;
    bus.int_ack   = 1'b0;
    bus.rd_strobe = 1'b0;
    #12;
    check("rst_irq", 32'(bus.irq_out), 32'd0);
    check("rst_key", 32'(bus.key_out), 32'd0);
    check("rst_cnt", 32'(bus.count), 32'd0);
    check("rst_ov", 32'(bus.overflow), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick(1);

    // 1) latency of a single 6-clk pulse
    bus.int_en   = 1'b1;
    bus.key_data = 8'h0A;
    bus.int_in   = 1'b1;
    tick(1);
    check("t1_cnt_e1", 32'(bus.count), 32'd0);
    tick(1);
    check("t1_cnt_e2", 32'(bus.count), 32'd1);
    check("t1_key_e2", 32'(bus.key_out), 32'h0A);
    check("t1_irq_e2", 32'(bus.irq_out), 32'd0);
    tick(1);
    check("t1_irq_e3", 32'(bus.irq_out), 32'd1);
    tick(3);
    bus.int_in = 1'b0;
    sb.push_back(8'h0A);
    tick(1);

    // 2) ack + read, then stray read on empty FIFO
    read_key("t2");
    tick(2);
    check("t2_irq_idle", 32'(bus.irq_out), 32'd0);
    bus.rd_strobe = 1'b1;
    tick(1);
    bus.rd_strobe = 1'b0;
    check("t2_rd_empty_cnt", 32'(bus.count), 32'd0);
    check("t2_rd_empty_key", 32'(bus.key_out), 32'd0);

    // 3) queued keys with interrupts disabled, then drained in order
    bus.int_en = 1'b0;
    send_key(8'h01, 6);
    send_key(8'h02, 6);
    send_key(8'h03, 6);
    tick(3);
    check("t3_no_irq", 32'(bus.irq_out), 32'd0);
    check("t3_cnt", 32'(bus.count), 32'd3);
    bus.int_en = 1'b1;
    for (int i = 0; i < 3; i++) read_key($sformatf("t3_rd%0d", i));

    // 4) runt pulse
    send_key(8'h44, 1);
    tick(3);
    check("t4_cnt", 32'(bus.count), 32'd0);
    check("t4_irq", 32'(bus.irq_out), 32'd0);

    // 5) overflow with five keys into a four-entry FIFO
    bus.int_en = 1'b0;
    check("t5_ov_pre", 32'(bus.overflow), 32'd0);
    for (int i = 0; i < 5; i++) send_key(8'h11 + 8'(i), 6);
    check("t5_cnt", 32'(bus.count), 32'(DEPTH));
    check("t5_ov", 32'(bus.overflow), 32'(ov_exp));
    bus.int_en = 1'b1;
    for (int i = 0; i < 4; i++) read_key($sformatf("t5_rd%0d", i));
    check("t5_ov_sticky", 32'(bus.overflow), 32'd1);

    // 6) withdraw on int_en drop, then async reset in SERVICE
    bus.int_en = 1'b0;
    send_key(8'h66, 6);
    bus.int_en = 1'b1;
    wait_irq("t6_irq");
    bus.int_en = 1'b0;
    tick(1);
    check("t6_withdraw", 32'(bus.irq_out), 32'd0);
    check("t6_cnt", 32'(bus.count), 32'd1);
    bus.int_en = 1'b1;
    wait_irq("t6_irq2");
    bus.int_ack = 1'b1;
    tick(1);
    bus.int_ack = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("t6_rst_irq", 32'(bus.irq_out), 32'd0);
    check("t6_rst_key", 32'(bus.key_out), 32'd0);
    check("t6_rst_cnt", 32'(bus.count), 32'd0);
    check("t6_rst_ov", 32'(bus.overflow), 32'd0);
    sb.delete();
    ov_exp = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    tick(1);

    // Post-reset key flows normally
    send_key(8'h77, 6);
    check("t7_key", 32'(bus.key_out), 32'h77);
    read_key("t7");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
